// File: rtl/apb_master_arb_if.sv
// Bundle of the two requester channels and the APB bus around apb_master_arb.
// master: the arbiter's view; slave: the environment (requesters + APB slave).
interface apb_master_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic                  req0_rnw;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic                  req0_ready;
   logic                  req0_done;
   logic [DATA_WIDTH-1:0] req0_rdata;
   logic                  req0_err;

   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic                  req1_rnw;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic                  req1_ready;
   logic                  req1_done;
   logic [DATA_WIDTH-1:0] req1_rdata;
   logic                  req1_err;

   logic [ADDR_WIDTH-1:0] apb_paddr;
   logic                  apb_psel;
   logic                  apb_penable;
   logic                  apb_pwrite;
   logic [DATA_WIDTH-1:0] apb_pwdata;
   logic [DATA_WIDTH-1:0] apb_prdata;
   logic                  apb_pready;

   modport master (
      input  req0_valid, req0_addr, req0_rnw, req0_wdata,
      output req0_ready, req0_done, req0_rdata, req0_err,
      input  req1_valid, req1_addr, req1_rnw, req1_wdata,
      output req1_ready, req1_done, req1_rdata, req1_err,
      output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
      input  apb_prdata, apb_pready
   );

   modport slave (
      output req0_valid, req0_addr, req0_rnw, req0_wdata,
      input  req0_ready, req0_done, req0_rdata, req0_err,
      output req1_valid, req1_addr, req1_rnw, req1_wdata,
      input  req1_ready, req1_done, req1_rdata, req1_err,
      input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
      output apb_prdata, apb_pready
   );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master: one SETUP/ACCESS transfer at a time.
// Optional ACCESS timeout abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic               clk,
   input  logic               nrst,
   apb_master_arb_if.master   bus,
   output logic [1:0]         dbg_state
);

   // Handshake: a request is accepted in the cycle where reqN_valid & reqN_ready
   // are both high; ready is only ever high in IDLE, for the granted requester.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;
   logic   owner;
   logic   grant_sel;
   logic   grant_vld;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] acc_cnt;
`endif

   // Grant the sole valid requester, or the one not served last time.
   always_comb begin
      grant_vld = bus.req0_valid | bus.req1_valid;
      grant_sel = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         grant_sel = ~last_grant;
      else
         grant_sel = bus.req1_valid;
   end

   assign bus.req0_ready = nrst && (state == IDLE) && bus.req0_valid && !grant_sel;
   assign bus.req1_ready = nrst && (state == IDLE) && bus.req1_valid &&  grant_sel;
   assign dbg_state      = state;

`ifndef APB_ARB_TIMEOUT_EN
   assign bus.req0_err = 1'b0;
   assign bus.req1_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state           <= IDLE;
         last_grant      <= 1'b1;
         owner           <= 1'b0;
         bus.apb_paddr   <= '0;
         bus.apb_psel    <= 1'b0;
         bus.apb_penable <= 1'b0;
         bus.apb_pwrite  <= 1'b0;
         bus.apb_pwdata  <= '0;
         bus.req0_done   <= 1'b0;
         bus.req1_done   <= 1'b0;
         bus.req0_rdata  <= '0;
         bus.req1_rdata  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         bus.req0_err    <= 1'b0;
         bus.req1_err    <= 1'b0;
         acc_cnt         <= '0;
`endif
      end else begin
         // Completion outputs are single-cycle pulses.
         bus.req0_done  <= 1'b0;
         bus.req1_done  <= 1'b0;
         bus.req0_rdata <= '0;
         bus.req1_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         bus.req0_err   <= 1'b0;
         bus.req1_err   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  bus.apb_paddr   <= grant_sel ? bus.req1_addr  : bus.req0_addr;
                  bus.apb_pwrite  <= grant_sel ? ~bus.req1_rnw  : ~bus.req0_rnw;
                  bus.apb_pwdata  <= grant_sel ? bus.req1_wdata : bus.req0_wdata;
                  owner           <= grant_sel;
                  last_grant      <= grant_sel;
                  bus.apb_psel    <= 1'b1;
                  bus.apb_penable <= 1'b0;
                  state           <= SETUP;
               end
            end

            SETUP: begin
               bus.apb_penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
               acc_cnt         <= '0;
`endif
               state           <= ACCESS;
            end

            ACCESS: begin
               if (bus.apb_pready) begin
                  bus.apb_psel    <= 1'b0;
                  bus.apb_penable <= 1'b0;
                  if (owner) begin
                     bus.req1_done  <= 1'b1;
                     bus.req1_rdata <= bus.apb_pwrite ? '0 : bus.apb_prdata;
                  end else begin
                     bus.req0_done  <= 1'b1;
                     bus.req0_rdata <= bus.apb_pwrite ? '0 : bus.apb_prdata;
                  end
                  state <= IDLE;
               end
`ifdef APB_ARB_TIMEOUT_EN
               // acc_cnt holds (ACCESS cycle index - 1); the last allowed cycle aborts.
               else if (acc_cnt == CNT_LAST) begin
                  bus.apb_psel    <= 1'b0;
                  bus.apb_penable <= 1'b0;
                  if (owner) begin
                     bus.req1_done <= 1'b1;
                     bus.req1_err  <= 1'b1;
                  end else begin
                     bus.req0_done <= 1'b1;
                     bus.req0_err  <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  acc_cnt <= acc_cnt + 1'b1;
               end
`endif
            end

            default: begin
               bus.apb_psel    <= 1'b0;
               bus.apb_penable <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed self-checking bench for apb_master_arb (timeout case follows APB_ARB_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_apb_master_arb;
   localparam int AW = 32;
   localparam int DW = 32;

   logic       clk  = 1'b0;
   logic       nrst = 1'b0;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [0:0] exp_q[$];

   apb_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   apb_master_arb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; leave time 1ns past the edge so registered outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen_done;
      logic g;
      bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_rnw = 0; bus.req0_wdata = '0;
      bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_rnw = 0; bus.req1_wdata = '0;
      bus.apb_prdata = '0; bus.apb_pready = 0;

      // Reset state
      nrst = 0;
      tick(); tick();
      bus.req0_valid = 1;
      #1;
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_psel", bus.apb_psel, 0);
      check("rst_penable", bus.apb_penable, 0);
      check("rst_done0", bus.req0_done, 0);
      check("rst_done1", bus.req1_done, 0);
      check("rst_err0", bus.req0_err, 0);
      check("rst_paddr", bus.apb_paddr, 0);
      check("rst_state", dbg_state, 0);
      bus.req0_valid = 0;
      nrst = 1;
      tick();

      // 1: req0 write, zero-wait slave
      bus.req0_valid = 1; bus.req0_addr = 32'h10; bus.req0_rnw = 0;
      bus.req0_wdata = 32'hCAFE_F00D; bus.apb_pready = 1;
      #1;
      check("t1_ready0", bus.req0_ready, 1);
      check("t1_ready1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 0;
      check("t1_psel", bus.apb_psel, 1);
      check("t1_penable_setup", bus.apb_penable, 0);
      check("t1_paddr", bus.apb_paddr, 32'h10);
      check("t1_pwrite", bus.apb_pwrite, 1);
      check("t1_pwdata", bus.apb_pwdata, 32'hCAFE_F00D);
      tick();
      check("t1_penable", bus.apb_penable, 1);
      check("t1_early_done0", bus.req0_done, 0);
      tick();
      check("t1_done0", bus.req0_done, 1);
      check("t1_err0", bus.req0_err, 0);
      check("t1_done1", bus.req1_done, 0);
      check("t1_psel_off", bus.apb_psel, 0);
      tick();
      check("t1_done0_clr", bus.req0_done, 0);
      check("t1_paddr_kept", bus.apb_paddr, 32'h10);

      // 2: req1 read, slave stalls 3 ACCESS cycles
      bus.req1_valid = 1; bus.req1_addr = 32'h24; bus.req1_rnw = 1;
      bus.apb_pready = 0; bus.apb_prdata = 32'hDEAD_BEEF;
      #1;
      check("t2_ready1", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 0;
      check("t2_pwrite", bus.apb_pwrite, 0);
      check("t2_paddr", bus.apb_paddr, 32'h24);
      tick();
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t2_psel_acc%0d", i), bus.apb_psel, 1);
         check($sformatf("t2_pen_acc%0d", i), bus.apb_penable, 1);
         check($sformatf("t2_paddr_acc%0d", i), bus.apb_paddr, 32'h24);
         check($sformatf("t2_done_acc%0d", i), bus.req1_done, 0);
         if (i == 4) begin
            bus.apb_pready = 1; bus.apb_prdata = 32'h1234_5678;
         end
         tick();
      end
      check("t2_done1", bus.req1_done, 1);
      check("t2_rdata1", bus.req1_rdata, 32'h1234_5678);
      check("t2_done0", bus.req0_done, 0);
      bus.apb_prdata = 32'hA5A5_0000;
      tick();
      check("t2_rdata1_clr", bus.req1_rdata, 0);

      // 3: both valid continuously, round-robin starting at req0
      bus.req0_valid = 1; bus.req0_addr = 32'h100; bus.req0_rnw = 0; bus.req0_wdata = 32'h1111;
      bus.req1_valid = 1; bus.req1_addr = 32'h200; bus.req1_rnw = 1;
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      #1;
      for (int i = 0; i < 4; i++) begin
         g = exp_q.pop_front();
         check($sformatf("t3_ready0_%0d", i), bus.req0_ready, !g);
         check($sformatf("t3_ready1_%0d", i), bus.req1_ready, g);
         tick();
         check($sformatf("t3_paddr_%0d", i), bus.apb_paddr, g ? 32'h200 : 32'h100);
         check($sformatf("t3_busy_ready_%0d", i), {bus.req0_ready, bus.req1_ready}, 2'b00);
         tick();
         check($sformatf("t3_penable_%0d", i), bus.apb_penable, 1);
         tick();
         check($sformatf("t3_done0_%0d", i), bus.req0_done, !g);
         check($sformatf("t3_done1_%0d", i), bus.req1_done, g);
         check($sformatf("t3_rdata1_%0d", i), bus.req1_rdata, g ? 32'hA5A5_0000 : 32'h0);
      end
      bus.req0_valid = 0; bus.req1_valid = 0;
      tick();
      check("t3_idle_psel", bus.apb_psel, 0);

      // 4: reset during ACCESS
      bus.req0_valid = 1; bus.req0_addr = 32'h44; bus.req0_wdata = 32'h55; bus.apb_pready = 0;
      tick();
      bus.req0_valid = 0;
      tick();
      check("t4_in_access", dbg_state, 2);
      nrst = 0; bus.req0_valid = 1; bus.req1_valid = 1;
      #1;
      check("t4_rst_ready0", bus.req0_ready, 0);
      check("t4_rst_ready1", bus.req1_ready, 0);
      tick();
      check("t4_psel", bus.apb_psel, 0);
      check("t4_penable", bus.apb_penable, 0);
      check("t4_done0", bus.req0_done, 0);
      check("t4_paddr", bus.apb_paddr, 0);
      check("t4_pwdata", bus.apb_pwdata, 0);
      tick();
      nrst = 1; bus.apb_pready = 1;
      #1;
      check("t4_first_ready0", bus.req0_ready, 1);
      check("t4_first_ready1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 0; bus.req1_valid = 0;
      check("t4_first_paddr", bus.apb_paddr, 32'h44);
      tick(); tick();
      check("t4_first_done0", bus.req0_done, 1);
      check("t4_first_done1", bus.req1_done, 0);
      tick();

      // 6: req0 withdraws its request while the FSM is busy
      bus.req1_valid = 1; bus.req1_addr = 32'h30; bus.req1_rnw = 1; bus.apb_pready = 0;
      tick();
      bus.req1_valid = 0;
      tick();
      bus.req0_valid = 1; bus.req0_addr = 32'h50;
      #1;
      check("t6_busy_ready0", bus.req0_ready, 0);
      tick();
      bus.req0_valid = 0;
      bus.apb_pready = 1;
      tick();
      check("t6_done1", bus.req1_done, 1);
      seen_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.apb_psel || bus.req0_done) seen_done = 1;
         tick();
      end
      check("t6_no_req0_xfer", seen_done, 0);

      // 5: slave never ready
      bus.req0_valid = 1; bus.req0_addr = 32'h60; bus.req0_rnw = 1;
      bus.apb_pready = 0; bus.apb_prdata = 32'hBEEF;
      tick();
      bus.req0_valid = 0;
      tick();
`ifdef APB_ARB_TIMEOUT_EN
      for (int i = 1; i <= 7; i++) begin
         check($sformatf("t5_wait_psel%0d", i), bus.apb_psel, 1);
         check($sformatf("t5_wait_done%0d", i), bus.req0_done, 0);
         tick();
      end
      tick();
      check("t5_abort_done0", bus.req0_done, 1);
      check("t5_abort_err0", bus.req0_err, 1);
      check("t5_abort_rdata0", bus.req0_rdata, 0);
      check("t5_abort_psel", bus.apb_psel, 0);
      check("t5_abort_penable", bus.apb_penable, 0);
`else
      seen_done = 0;
      for (int i = 0; i < 1000; i++) begin
         if (bus.req0_done || !bus.apb_psel) seen_done = 1;
         tick();
      end
      check("t5_still_waiting", seen_done, 0);
      check("t5_penable", bus.apb_penable, 1);
      bus.apb_pready = 1;
      tick();
      check("t5_late_done0", bus.req0_done, 1);
      check("t5_late_err0", bus.req0_err, 0);
      check("t5_late_rdata0", bus.req0_rdata, 32'hBEEF);
`endif
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
